scariv_uc_store_queue: RTL and testbench

//  In-order queue of committed uncached (UC/IO) stores between the store commit path and the
//  L2 store requestor's uc_write port. The downstream port holds only one UC store, so this block

---
 rtl/scariv_lsu_pkg.sv | 23 ++
 rtl/scariv_uc_store_queue_if.sv | 17 +
 rtl/scariv_uc_store_queue.sv | 154 +++++++++++++++
 tb/tb_scariv_uc_store_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scariv_lsu_pkg.sv
// Shared types for the uncached store queue.
// scariv_lsu_pkg: default sizes, entry layout and fence drain FSM states.
package scariv_lsu_pkg;

    localparam int unsigned UCSQ_DEPTH   = 4;
    localparam int unsigned UCSQ_PADDR_W = 56;
    localparam int unsigned UCSQ_XLEN_W  = 64;

    // Entry layout at the default widths
    typedef struct packed {
        logic                    valid;
        logic [UCSQ_PADDR_W-1:0] paddr;
        logic [UCSQ_XLEN_W-1:0]  data;
        logic [1:0]              size;
    } ucsq_entry_t;

    typedef enum logic [1:0] {
        UCSQ_IDLE,
        UCSQ_DRAIN,
        UCSQ_DONE
    } ucsq_fence_state_t;

endpackage

// File: rtl/scariv_uc_store_queue_if.sv
// Store channel (valid/ready + address, data, size).
// Used for both the commit-side enqueue port and the uc_write port to the L2 requestor.
interface scariv_uc_store_queue_if
    import scariv_lsu_pkg::*;
#(
    parameter int unsigned PADDR_W = UCSQ_PADDR_W,
    parameter int unsigned XLEN_W  = UCSQ_XLEN_W
);
    logic               valid;
    logic               ready;
    logic [PADDR_W-1:0] paddr;
    logic [XLEN_W-1:0]  data;
    logic [1:0]         size;

    modport master (output valid, paddr, data, size, input  ready);
    modport slave  (input  valid, paddr, data, size, output ready);
endinterface

// File: rtl/scariv_uc_store_queue.sv
// In-order queue of committed uncached stores feeding the L2 uc_write port.
// Blocks loads that hit a buffered dword and runs the fence drain handshake.
// Optional: define SCARIV_UCSQ_PERF_EN to build the saturating perf counters.
module scariv_uc_store_queue
    import scariv_lsu_pkg::*;
#(
    parameter int unsigned DEPTH   = UCSQ_DEPTH,
    parameter int unsigned PADDR_W = UCSQ_PADDR_W,
    parameter int unsigned XLEN_W  = UCSQ_XLEN_W
)(
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    scariv_uc_store_queue_if.slave     enq,
    scariv_uc_store_queue_if.master    uc,
    input  logic                       i_uc_is_empty,
    input  logic                       i_fwd_valid,
    input  logic [PADDR_W-1:0]         i_fwd_paddr,
    output logic                       o_fwd_conflict,
    input  logic                       i_fence_req,
    output logic                       o_fence_done,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [31:0]                o_perf_enq,
    output logic [31:0]                o_perf_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [XLEN_W-1:0]  data;
        logic [1:0]         size;
    } entry_t;

    logic [DEPTH-1:0]  valid_q;
    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    ucsq_fence_state_t state_q;
    ucsq_fence_state_t state_d;
    logic              full;
    logic              enq_fire;
    logic              deq_fire;
    logic              fwd_hit;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign enq.ready = !full && (state_q != UCSQ_DRAIN);
    assign enq_fire  = enq.valid && enq.ready;
    assign deq_fire  = uc.valid && uc.ready;

    assign uc.valid  = valid_q[rd_ptr_q];
    assign uc.paddr  = mem_q[rd_ptr_q].paddr;
    assign uc.data   = mem_q[rd_ptr_q].data;
    assign uc.size   = mem_q[rd_ptr_q].size;

    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;

    // Valid bits, pointers and occupancy; pointers wrap since DEPTH is a power of 2
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq_fire) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (enq_fire && !deq_fire) begin
                count_q <= count_q + 1'b1;
            end else if (!enq_fire && deq_fire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Payload storage, written at the tail; not reset
    always_ff @(posedge i_clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q] <= '{paddr: enq.paddr, data: enq.data, size: enq.size};
        end
    end

    // Dword-granular overlap of the load probe against every buffered store
    always_comb begin
        fwd_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (mem_q[i].paddr[PADDR_W-1:3] == i_fwd_paddr[PADDR_W-1:3])) begin
                fwd_hit = 1'b1;
            end
        end
    end

    assign o_fwd_conflict = i_fwd_valid && fwd_hit;

    // Fence FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= UCSQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fence FSM next state and done pulse; DRAIN is always visited so done lags the request by 2
    always_comb begin
        state_d      = state_q;
        o_fence_done = 1'b0;
        case (state_q)
            UCSQ_IDLE:  if (i_fence_req) state_d = UCSQ_DRAIN;
            UCSQ_DRAIN: if (o_empty && i_uc_is_empty) state_d = UCSQ_DONE;
            UCSQ_DONE: begin
                o_fence_done = 1'b1;
                state_d      = UCSQ_IDLE;
            end
            default:    state_d = UCSQ_IDLE;
        endcase
    end

`ifdef SCARIV_UCSQ_PERF_EN
    logic [31:0] perf_enq_q;
    logic [31:0] perf_full_q;

    // Saturating counts of enqueues and of stalled-full cycles
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_enq_q  <= '0;
            perf_full_q <= '0;
        end else begin
            if (enq_fire && (perf_enq_q != '1)) begin
                perf_enq_q <= perf_enq_q + 32'd1;
            end
            if (full && enq.valid && (perf_full_q != '1)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign o_perf_enq  = perf_enq_q;
    assign o_perf_full = perf_full_q;
`else
    assign o_perf_enq  = '0;
    assign o_perf_full = '0;
`endif

endmodule

// File: tb/tb_scariv_uc_store_queue.sv
// Directed bench for scariv_uc_store_queue: per-cycle vector table plus a reset sequence.
// Inputs change on the falling edge; outputs are compared 1ns later, before the next rising edge.
module tb_scariv_uc_store_queue;

    logic        clk;
    logic        rst_n;
    logic        uc_is_empty;
    logic        fwd_valid;
    logic [55:0] fwd_paddr;
    logic        fwd_conflict;
    logic        fence_req;
    logic        fence_done;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] perf_enq;
    logic [31:0] perf_full;

    int unsigned total;
    int unsigned bad;

    scariv_uc_store_queue_if #(.PADDR_W(56), .XLEN_W(64)) enq_if ();
    scariv_uc_store_queue_if #(.PADDR_W(56), .XLEN_W(64)) uc_if ();

    scariv_uc_store_queue #(.DEPTH(4), .PADDR_W(56), .XLEN_W(64)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .enq            (enq_if),
        .uc             (uc_if),
        .i_uc_is_empty  (uc_is_empty),
        .i_fwd_valid    (fwd_valid),
        .i_fwd_paddr    (fwd_paddr),
        .o_fwd_conflict (fwd_conflict),
        .i_fence_req    (fence_req),
        .o_fence_done   (fence_done),
        .o_empty        (empty),
        .o_count        (count),
        .o_perf_enq     (perf_enq),
        .o_perf_full    (perf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        enq_v;
        logic [55:0] enq_a;
        logic [63:0] enq_d;
        logic [1:0]  enq_s;
        logic        uc_rdy;
        logic        uc_emp;
        logic        fwd_v;
        logic [55:0] fwd_a;
        logic        fence;
        logic        e_rdy;
        logic        e_ucv;
        logic [55:0] e_a;
        logic [63:0] e_d;
        logic [1:0]  e_s;
        logic [2:0]  e_cnt;
        logic        e_cf;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int unsigned ev, int unsigned ea, int unsigned ed, int unsigned es,
                                int unsigned ur, int unsigned ue, int unsigned fv, int unsigned fa,
                                int unsigned fn, int unsigned er, int unsigned eu, int unsigned xa,
                                int unsigned xd, int unsigned xs, int unsigned ec, int unsigned ecf,
                                int unsigned edn);
        vec_t v;
        v.enq_v  = ev[0];
        v.enq_a  = 56'(ea);
        v.enq_d  = 64'(ed);
        v.enq_s  = es[1:0];
        v.uc_rdy = ur[0];
        v.uc_emp = ue[0];
        v.fwd_v  = fv[0];
        v.fwd_a  = 56'(fa);
        v.fence  = fn[0];
        v.e_rdy  = er[0];
        v.e_ucv  = eu[0];
        v.e_a    = 56'(xa);
        v.e_d    = 64'(xd);
        v.e_s    = xs[1:0];
        v.e_cnt  = ec[2:0];
        v.e_cf   = ecf[0];
        v.e_done = edn[0];
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic ev, logic [55:0] ea, logic [63:0] ed, logic [1:0] es, logic ur);
        enq_if.valid = ev;
        enq_if.paddr = ea;
        enq_if.data  = ed;
        enq_if.size  = es;
        uc_if.ready  = ur;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        uc_is_empty = 1'b1;
        fwd_valid   = 1'b0;
        fwd_paddr   = '0;
        fence_req   = 1'b0;
        drive(1'b0, '0, '0, 2'd0, 1'b0);

        //   ev ea          ed      es  ur ue  fv fa      fn  er eu xa          xd      xs  ec cf dn
        // single store, 1-cycle latency
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(1, 'h80000010, 'h1234, 2,  1, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h80000010, 'h1234, 2,  1, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        // five enqueues with the port stalled, then drain in order
        add(1, 'h100,      'hA0,   0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(1, 'h108,      'hB0,   1,  0, 1,  0, 0,      0,  1, 1, 'h100,      'hA0,   0,  1, 0, 0);
        add(1, 'h110,      'hC0,   2,  0, 1,  0, 0,      0,  1, 1, 'h100,      'hA0,   0,  2, 0, 0);
        add(1, 'h118,      'hD0,   3,  0, 1,  0, 0,      0,  1, 1, 'h100,      'hA0,   0,  3, 0, 0);
        add(1, 'h120,      'hE0,   3,  0, 1,  0, 0,      0,  0, 1, 'h100,      'hA0,   0,  4, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  0, 1, 'h100,      'hA0,   0,  4, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  0, 1, 'h100,      'hA0,   0,  4, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h108,      'hB0,   1,  3, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h110,      'hC0,   2,  2, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h118,      'hD0,   3,  1, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        // full queue with simultaneous enqueue and dequeue
        add(1, 'h200,      'h11,   3,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(1, 'h208,      'h22,   3,  0, 1,  0, 0,      0,  1, 1, 'h200,      'h11,   3,  1, 0, 0);
        add(1, 'h210,      'h33,   3,  0, 1,  0, 0,      0,  1, 1, 'h200,      'h11,   3,  2, 0, 0);
        add(1, 'h218,      'h44,   3,  0, 1,  0, 0,      0,  1, 1, 'h200,      'h11,   3,  3, 0, 0);
        add(1, 'h220,      'h55,   3,  1, 1,  0, 0,      0,  0, 1, 'h200,      'h11,   3,  4, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 1, 'h208,      'h22,   3,  3, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h208,      'h22,   3,  3, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h210,      'h33,   3,  2, 0, 0);
        add(0, 0,          0,      0,  1, 1,  0, 0,      0,  1, 1, 'h218,      'h44,   3,  1, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        // load probes against a buffered dword
        add(1, 'h1008,     'h66,   0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  1, 'h100C, 0,  1, 1, 'h1008,     'h66,   0,  1, 1, 0);
        add(0, 0,          0,      0,  0, 1,  1, 'h1010, 0,  1, 1, 'h1008,     'h66,   0,  1, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 'h100C, 0,  1, 1, 'h1008,     'h66,   0,  1, 0, 0);
        add(0, 0,          0,      0,  0, 1,  1, 'h1000, 0,  1, 1, 'h1008,     'h66,   0,  1, 0, 0);
        add(0, 0,          0,      0,  1, 1,  1, 'h1008, 0,  1, 1, 'h1008,     'h66,   0,  1, 1, 0);
        add(0, 0,          0,      0,  0, 1,  1, 'h1008, 0,  1, 0, 0,          0,      0,  0, 0, 0);
        // fence with two stores buffered and the requestor busy
        add(1, 'h300,      'h77,   2,  0, 0,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        add(1, 'h308,      'h88,   1,  0, 0,  0, 0,      0,  1, 1, 'h300,      'h77,   2,  1, 0, 0);
        add(0, 0,          0,      0,  0, 0,  0, 0,      1,  1, 1, 'h300,      'h77,   2,  2, 0, 0);
        add(1, 'h310,      'h99,   0,  0, 0,  0, 0,      0,  0, 1, 'h300,      'h77,   2,  2, 0, 0);
        add(0, 0,          0,      0,  1, 0,  0, 0,      0,  0, 1, 'h300,      'h77,   2,  2, 0, 0);
        add(0, 0,          0,      0,  1, 0,  0, 0,      0,  0, 1, 'h308,      'h88,   1,  1, 0, 0);
        add(0, 0,          0,      0,  0, 0,  0, 0,      0,  0, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  0, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 1);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        // fence on an already drained queue: done two cycles after the request
        add(0, 0,          0,      0,  0, 1,  0, 0,      1,  1, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  0, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 1);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);
        // request held high: a second fence starts after the first completes
        add(0, 0,          0,      0,  0, 1,  0, 0,      1,  1, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      1,  0, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      1,  1, 0, 0,          0,      0,  0, 0, 1);
        add(0, 0,          0,      0,  0, 1,  0, 0,      1,  1, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  0, 0, 0,          0,      0,  0, 0, 0);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 1);
        add(0, 0,          0,      0,  0, 1,  0, 0,      0,  1, 0, 0,          0,      0,  0, 0, 0);

        // reset state while reset is held
        repeat (2) @(negedge clk);
        #1;
        chk("reset_empty", longint'(empty), 1);
        chk("reset_count", longint'(count), 0);
        chk("reset_uc_valid", longint'(uc_if.valid), 0);
        chk("reset_fence_done", longint'(fence_done), 0);
        chk("reset_perf_enq", longint'(perf_enq), 0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].enq_v, tbl[k].enq_a, tbl[k].enq_d, tbl[k].enq_s, tbl[k].uc_rdy);
            uc_is_empty = tbl[k].uc_emp;
            fwd_valid   = tbl[k].fwd_v;
            fwd_paddr   = tbl[k].fwd_a;
            fence_req   = tbl[k].fence;
            #1;
            chk($sformatf("v%0d_enq_ready", k), longint'(enq_if.ready), longint'(tbl[k].e_rdy));
            chk($sformatf("v%0d_uc_valid", k), longint'(uc_if.valid), longint'(tbl[k].e_ucv));
            chk($sformatf("v%0d_count", k), longint'(count), longint'(tbl[k].e_cnt));
            chk($sformatf("v%0d_empty", k), longint'(empty), longint'(tbl[k].e_cnt == 3'd0));
            chk($sformatf("v%0d_fwd_conflict", k), longint'(fwd_conflict), longint'(tbl[k].e_cf));
            chk($sformatf("v%0d_fence_done", k), longint'(fence_done), longint'(tbl[k].e_done));
            if (tbl[k].e_ucv) begin
                chk($sformatf("v%0d_uc_paddr", k), longint'(uc_if.paddr), longint'(tbl[k].e_a));
                chk($sformatf("v%0d_uc_data", k), longint'(uc_if.data), longint'(tbl[k].e_d));
                chk($sformatf("v%0d_uc_size", k), longint'(uc_if.size), longint'(tbl[k].e_s));
            end
        end

        @(negedge clk);
        drive(1'b0, '0, '0, 2'd0, 1'b0);
        fence_req = 1'b0;
        fwd_valid = 1'b0;
        #1;
`ifdef SCARIV_UCSQ_PERF_EN
        chk("perf_enq_total", longint'(perf_enq), 12);
        chk("perf_full_total", longint'(perf_full), 2);
`else
        chk("perf_enq_tied", longint'(perf_enq), 0);
        chk("perf_full_tied", longint'(perf_full), 0);
`endif

        // asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 56'h400 + 56'(8 * i), 64'h500 + 64'(i), 2'd3, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 2'd0, 1'b0);
        #1;
        chk("pre_reset_count", longint'(count), 3);
        chk("pre_reset_uc_valid", longint'(uc_if.valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_empty", longint'(empty), 1);
        chk("async_reset_uc_valid", longint'(uc_if.valid), 0);
        chk("async_reset_count", longint'(count), 0);
        chk("async_reset_perf_enq", longint'(perf_enq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 56'h600 + 56'(8 * i), 64'h700 + 64'(i), 2'd1, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 2'd0, 1'b0);
        #1;
        chk("post_reset_count", longint'(count), 3);
        chk("post_reset_head_paddr", longint'(uc_if.paddr), 'h600);
        chk("post_reset_head_data", longint'(uc_if.data), 'h700);
`ifdef SCARIV_UCSQ_PERF_EN
        chk("post_reset_perf_enq", longint'(perf_enq), 3);
`else
        chk("post_reset_perf_enq", longint'(perf_enq), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
